multicycle_controller: RTL

//  Sequencing FSM for the multicycle RV32I core: shares one memory port between instruction fetch and data access.

---
 rtl/cpu_defines.sv | 71 +++++++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - opcodes, state encodings and datapath select codes for the multicycle RV32I core
package cpu_defines;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_JAL       = 4'd9,
        S_BRANCH    = 4'd10,
        S_LUI       = 4'd11,
        S_FAULT     = 4'd12
    } state_t;

    // Which operation family the ALU decoder is asked for in the current state.
    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_R   = 2'd2,
        MODE_I   = 2'd3
    } alu_mode_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_OLD_PC = 2'b01;
    localparam logic [1:0] A_RS1    = 2'b10;

    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;

    function automatic logic [2:0] imm_select_for(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps state class and funct fields to ALU_control, flags unsupported funct3
module alu_decoder
    import cpu_defines::*;
(
    input  alu_mode_t  alu_mode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_mode)
            MODE_SUB: alu_control = ALU_SUB;
            MODE_R, MODE_I: begin
                case (funct3)
                    3'b000:  alu_control = (alu_mode == MODE_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
        // Legality depends only on funct3 so DECODE can use it before the execute state.
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
            default:                        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I sequencing FSM with shared memory port and wait timeout
module multicycle_controller
    import cpu_defines::*;
#(
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_WIDTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       memory_ready,
    output logic       pc_write,
    output logic       address_select,
    output logic       memory_read,
    output logic       memory_write,
    output logic       instruction_write,
    output logic       reg_write,
    output logic [1:0] result_select,
    output logic [1:0] ALU_select_A,
    output logic [1:0] ALU_select_B,
    output logic [2:0] ALU_control,
    output logic [2:0] immediate_select,
    output logic [3:0] state,
    output logic       fault
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);

    state_t                state_q;
    state_t                state_next;
    logic [WAIT_WIDTH-1:0] wait_count;
    alu_mode_t             alu_mode;
    logic [2:0]            alu_code;
    logic                  funct3_illegal;
    logic                  mem_state;
    logic                  timeout;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout   = mem_state && !memory_ready && (wait_count == WAIT_LIMIT);
    assign state     = state_q;

    always_comb begin
        alu_mode = MODE_ADD;
        case (state_q)
            S_EXEC_R: alu_mode = MODE_R;
            S_EXEC_I: alu_mode = MODE_I;
            S_BRANCH: alu_mode = MODE_SUB;
            default:  alu_mode = MODE_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_mode    (alu_mode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (alu_code),
        .illegal     (funct3_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Counts consecutive not-ready cycles of the current memory access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_count <= '0;
        end else if (state_next != state_q &&
                     (state_next == S_FETCH || state_next == S_MEM_READ || state_next == S_MEM_WRITE)) begin
            wait_count <= '0;
        end else if (mem_state && !memory_ready && wait_count != WAIT_LIMIT) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    always_comb begin
        state_next        = state_q;
        pc_write          = 1'b0;
        address_select    = 1'b0;
        memory_read       = 1'b0;
        memory_write      = 1'b0;
        instruction_write = 1'b0;
        reg_write         = 1'b0;
        result_select     = RES_ALU_OUT;
        ALU_select_A      = A_PC;
        ALU_select_B      = B_RS2;
        ALU_control       = alu_code;
        immediate_select  = IMM_I;
        fault             = 1'b0;

        case (state_q)
            S_FETCH: begin
                memory_read   = !timeout;
                result_select = RES_ALU;
                ALU_select_B  = B_FOUR;
                if (memory_ready) begin
                    instruction_write = 1'b1;
                    pc_write          = 1'b1;
                    state_next        = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                ALU_select_A     = A_OLD_PC;
                ALU_select_B     = B_IMM;
                immediate_select = imm_select_for(opcode);
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = (funct3 == 3'b010) ? S_MEM_ADDR : S_FAULT;
                    OP_R:              state_next = funct3_illegal ? S_FAULT : S_EXEC_R;
                    OP_I:              state_next = funct3_illegal ? S_FAULT : S_EXEC_I;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_FAULT;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                ALU_select_A     = A_RS1;
                ALU_select_B     = B_IMM;
                immediate_select = imm_select_for(opcode);
                state_next       = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                address_select = 1'b1;
                memory_read    = !timeout;
                if (memory_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_MEM_WB: begin
                result_select = RES_DATA;
                reg_write     = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEM_WRITE: begin
                address_select = 1'b1;
                memory_write   = !timeout;
                if (memory_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_EXEC_R: begin
                ALU_select_A = A_RS1;
                ALU_select_B = B_RS2;
                state_next   = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_select_A     = A_RS1;
                ALU_select_B     = B_IMM;
                immediate_select = IMM_I;
                state_next       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALU_select_A = A_OLD_PC;
                ALU_select_B = B_FOUR;
                pc_write     = 1'b1;
                state_next   = S_ALU_WB;
            end
            S_BRANCH: begin
                ALU_select_A = A_RS1;
                ALU_select_B = B_RS2;
                pc_write     = funct3[0] ? !zero : zero;
                state_next   = S_FETCH;
            end
            S_LUI: begin
                result_select    = RES_IMM;
                immediate_select = IMM_U;
                reg_write        = 1'b1;
                state_next       = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_next = S_FAULT;
        endcase

        // Reset is asynchronous, so the outputs are silenced combinationally too.
        if (!reset) begin
            pc_write          = 1'b0;
            address_select    = 1'b0;
            memory_read       = 1'b0;
            memory_write      = 1'b0;
            instruction_write = 1'b0;
            reg_write         = 1'b0;
            result_select     = 2'b00;
            ALU_select_A      = 2'b00;
            ALU_select_B      = 2'b00;
            ALU_control       = 3'b000;
            immediate_select  = 3'b000;
            fault             = 1'b0;
        end
    end

endmodule
